xor_share_arbiter: RTL and testbench

//   Shares one 2-input XOR cell (switch-level xor2) among N requesters.

---
 rtl/xor_share_arbiter.sv | 110 +++++++++++
 tb/tb_xor_share_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one switch-level xor2 cell among N requesters.
// Latency: gnt one clock after request, ack SETTLE_CYC clocks after gnt; one op per SETTLE_CYC+2 clocks.
// Backpressure: requesters hold req until their one-cycle ack; others wait, served in pointer order.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   req/a_in/b_in  per-requester request level and operands
//   gnt/ack        one-hot grant (whole op) and one-hot one-cycle completion pulse
//   res_out        XOR result, valid while ack is high, held until the next capture
//   busy           high while an op is settling or completing
//   xa/xb/xc       operands to and result from the shared xor2 cell
module xor_share_arbiter #(
  parameter int N          = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic [N-1:0] gnt,
  output logic [N-1:0] ack,
  output logic         res_out,
  output logic         busy,
  output logic         xa,
  output logic         xb,
  input  logic         xc
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;    // highest-priority requester for the next arbitration
  logic [IW-1:0] w;      // winner of the op in flight
  logic [CW-1:0] cnt;    // settle clocks remaining after the current one
  logic [IW-1:0] win;
  logic [IW-1:0] idx;
  logic          found;

  // Rotating priority search: first set req bit at ptr, ptr+1, ... mod N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      ack     <= '0;
      busy    <= 1'b0;
      res_out <= 1'b0;
      xa      <= 1'b0;
      xb      <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      w       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // xa/xb keep their last values while nobody is requesting.
          if (found) begin
            w     <= win;
            gnt   <= ONE << win;
            xa    <= a_in[win];
            xb    <= b_in[win];
            cnt   <= CW'(SETTLE_CYC - 1);
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // Operands stay frozen; the cell gets SETTLE_CYC full clocks before xc is sampled.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            res_out <= xc;
            ack     <= ONE << w;
            state   <= DONE;
          end
        end
        DONE: begin
          ack   <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          ptr   <= (w == IW'(N - 1)) ? '0 : w + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Self-checking bench for xor_share_arbiter against a timeline-based reference model.
// Latency: checks every cycle 1 time unit after the rising edge.
// Backpressure: requesters hold req until acked; the bench models the shared xor2 cell.
module tb_xor_share_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req, a_in, b_in;
  logic [N-1:0] gnt, ack;
  logic         res_out, busy, xa, xb, xc;

  xor_share_arbiter #(.N(N), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .ack(ack), .res_out(res_out), .busy(busy),
    .xa(xa), .xb(xb), .xc(xc)
  );

  // Behavioural stand-in for the shared xor2 cell.
  assign xc = xa ^ xb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: an op is a time window [start, start+S+1] on the edge count.
  bit           m_active;
  int           m_start, m_w, m_ptr;
  logic [N-1:0] m_gnt, m_ack;
  logic         m_busy, m_xa, m_xb, m_res;

  logic [N-1:0] prev_gnt;
  int           grants[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_active = 0; m_ptr = 0; m_gnt = '0; m_ack = '0;
      m_busy = 0; m_xa = 0; m_xb = 0; m_res = 0;
      return;
    end
    if (m_active) begin
      if (cyc == m_start + S) begin
        m_res = m_xa ^ m_xb;
        m_ack[m_w] = 1'b1;
      end else if (cyc == m_start + S + 1) begin
        m_active = 0; m_gnt = '0; m_ack = '0; m_busy = 0;
        m_ptr = (m_w + 1) % N;
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_w = (m_ptr + k) % N;
          break;
        end
      end
      m_active = 1; m_start = cyc; m_busy = 1;
      m_gnt = '0; m_gnt[m_w] = 1'b1;
      m_xa = a_in[m_w]; m_xb = b_in[m_w];
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("gnt", gnt, m_gnt);
    chk("ack", ack, m_ack);
    chk("busy", busy, m_busy);
    chk("xa", xa, m_xa);
    chk("xb", xb, m_xb);
    chk("res_out", res_out, m_res);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("ack_onehot0", $onehot0(ack), 1);
    chk("ack_in_gnt", (ack & ~gnt) == '0, 1);
    if (gnt != prev_gnt && gnt != '0)
      for (int i = 0; i < N; i++) if (gnt[i]) grants.push_back(i);
    prev_gnt = gnt;
    for (int i = 0; i < N; i++) if (m_ack[i]) req[i] = 1'b0;
  endtask

  task automatic wait_ack(input int i, output int gap);
    int tg;
    bit seen;
    tg = -1; gap = -1; seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      step();
      if (gnt[i] && tg < 0) tg = cyc;
      if (ack[i]) begin seen = 1; gap = cyc - tg; end
    end
    chk("ack_seen", seen, 1);
  endtask

  task automatic run_until_grants(input int n, input bit reassert);
    logic [N-1:0] held;
    held = req;
    for (int k = 0; k < 100 && grants.size() < n; k++) begin
      step();
      if (reassert)
        for (int i = 0; i < N; i++) if (held[i] && !req[i] && !m_ack[i]) req[i] = 1'b1;
    end
    chk("grant_count", grants.size(), n);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (req != '0 || busy); k++) step();
    step();
  endtask

  int gap;
  int exp_xor[4] = '{0, 1, 1, 0};
  int exp_fair[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; prev_gnt = '0;
    m_active = 0; m_start = 0; m_w = 0; m_ptr = 0;
    m_gnt = '0; m_ack = '0; m_busy = 0; m_xa = 0; m_xb = 0; m_res = 0;

    // Reset state
    step(); step();
    chk("rst_gnt", gnt, 0); chk("rst_ack", ack, 0); chk("rst_busy", busy, 0);
    chk("rst_res", res_out, 0); chk("rst_xa", xa, 0); chk("rst_xb", xb, 0);
    rst = 1'b0;
    step();

    // Single requester timing
    req = 4'b0001; a_in = 4'b0001; b_in = 4'b0000;
    step();
    chk("t1_gnt", gnt, 4'b0001); chk("t1_xa", xa, 1); chk("t1_xb", xb, 0);
    step();
    chk("t1_no_ack_e1", ack, 0);
    step();
    chk("t1_ack", ack, 4'b0001); chk("t1_res", res_out, 1);
    step();
    chk("t1_ack_drop", ack, 0); chk("t1_res_hold", res_out, 1);
    drain();

    // Truth table on requester 2
    for (int k = 0; k < 4; k++) begin
      a_in[2] = k[1]; b_in[2] = k[0]; req[2] = 1'b1;
      wait_ack(2, gap);
      chk("t2_res", res_out, exp_xor[k]);
      chk("t2_gap", gap, S);
    end
    drain();

    // Fairness from ptr=0 with all requesters continuously requesting
    rst = 1'b1; step(); rst = 1'b0;
    grants.delete();
    req = 4'b1111;
    run_until_grants(5, 1'b1);
    for (int k = 0; k < 5 && k < grants.size(); k++) chk("t3_order", grants[k], exp_fair[k]);
    req = '0;
    drain();

    // Pointer wrap: serve 2, then 3 and 0 contend
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b0100;
    wait_ack(2, gap);
    req = 4'b1001;
    grants.delete();
    run_until_grants(2, 1'b0);
    if (grants.size() >= 2) begin
      chk("t4_first", grants[0], 3);
      chk("t4_second", grants[1], 0);
    end
    drain();

    // Operand and req change mid-op
    req = 4'b0010; a_in = 4'b0010; b_in = 4'b0010;
    step();
    chk("t5_gnt", gnt, 4'b0010);
    a_in[1] = 1'b0; req[1] = 1'b0;
    step();
    chk("t5_xa_held", xa, 1);
    wait_ack(1, gap);
    chk("t5_res", res_out, 0);
    drain();

    // Reset mid-op: ptr=2, requester 3 wins, reset, then requester 1 wins from ptr=0
    req = 4'b1010; a_in = 4'b1111; b_in = 4'b0000;
    step();
    chk("t6_gnt_pre", gnt, 4'b1000);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_gnt", gnt, 0); chk("t6_ack", ack, 0); chk("t6_busy", busy, 0);
    chk("t6_xa", xa, 0); chk("t6_xb", xb, 0);
    grants.delete();
    run_until_grants(1, 1'b0);
    if (grants.size() >= 1) chk("t6_regrant", grants[0], 1);
    drain();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      a_in = N'($urandom);
      b_in = N'($urandom);
      rst  = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
